// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle control unit for the processor datapath. Accepts one 9-bit
//   instruction per valid/ready handshake and sequences the bus-mux select
//   (ctrlVar) plus the register-load, ALU-op and register-write strobes.
//
//   Ports:
//     clk          clock, all state changes on the rising edge
//     rst          synchronous active-high reset
//     instr_valid  instruction present on instr
//     instr_ready  sequencer can accept an instruction (IDLE only)
//     instr[8:0]   [8:6] opcode, [5:3] rx, [2:0] ry
//     ctrlVar[3:0] bus mux select (0..7 = R0..R7, SEL_G, SEL_DIN, SEL_IDLE)
//     ld_a         latch bus into ALU operand A
//     ld_g         latch ALU(A, bus) into G
//     alu_op[1:0]  00 add, 01 sub, 10 and
//     wr_en        write bus into register wr_addr
//     wr_addr[2:0] destination register index
//     done         one-cycle pulse in the final cycle of each instruction
//     illegal      sticky illegal-opcode flag (trap build only, else 0)
//
//   Build option:
//     SEQ_ILLEGAL_TRAP_EN  defined: illegal opcodes halt the sequencer until
//                          rst. Undefined: illegal opcodes execute as a NOP.
module control_sequencer #(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [3:0]  SEL_G    = 4'd8,
  parameter logic [3:0]  SEL_DIN  = 4'd9,
  parameter logic [3:0]  SEL_IDLE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [8:0] instr,
  output logic [3:0] ctrlVar,
  output logic       ld_a,
  output logic       ld_g,
  output logic [1:0] alu_op,
  output logic       wr_en,
  output logic [2:0] wr_addr,
  output logic       done,
  output logic       illegal
);

  localparam int unsigned RW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100
  } opcode_t;

`ifdef SEQ_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HALT = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;
`endif

  state_t          state, state_nx;
  logic [8:0]      ir;
  logic [2:0]      op;
  logic [RW-1:0]   rx, ry;
  logic            illegal_c;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && instr_valid)
        ir <= instr;
    end
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    ctrlVar     = SEL_IDLE;
    ld_a        = 1'b0;
    ld_g        = 1'b0;
    alu_op      = 2'b00;
    wr_en       = 1'b0;
    wr_addr     = '0;
    done        = 1'b0;
    illegal_c   = 1'b0;

    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nx = S_T1;
      end

      S_T1: begin
        case (op)
          OP_MV: begin
            ctrlVar  = 4'(ry);
            wr_en    = 1'b1;
            wr_addr  = rx;
            done     = 1'b1;
            state_nx = S_IDLE;
          end
          OP_MVI: begin
            ctrlVar  = SEL_DIN;
            wr_en    = 1'b1;
            wr_addr  = rx;
            done     = 1'b1;
            state_nx = S_IDLE;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            ctrlVar  = 4'(rx);
            ld_a     = 1'b1;
            state_nx = S_T2;
          end
          default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            state_nx = S_HALT;
`else
            done     = 1'b1;
            state_nx = S_IDLE;
`endif
          end
        endcase
      end

      S_T2: begin
        ctrlVar  = 4'(ry);
        ld_g     = 1'b1;
        case (op)
          OP_SUB:  alu_op = 2'b01;
          OP_AND:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
        state_nx = S_T3;
      end

      S_T3: begin
        ctrlVar  = SEL_G;
        wr_en    = 1'b1;
        wr_addr  = rx;
        done     = 1'b1;
        state_nx = S_IDLE;
      end

`ifdef SEQ_ILLEGAL_TRAP_EN
      // Sticky: HALT is left only through rst.
      S_HALT: begin
        illegal_c = 1'b1;
        state_nx  = S_HALT;
      end
`endif

      default: state_nx = S_IDLE;
    endcase
  end

  assign illegal = illegal_c;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit for the processor datapath. Accepts one 9-bit instruction per valid/ready handshake and steps a small state machine that drives the 4-bit source select of the datapath's 10:1 bus multiplexer, together with the register-load, ALU-op and register-write strobes. Sits directly upstream of the bus multiplexer: its `ctrlVar` output is that mux's select input.

## Interface
Parameters:
- `NUM_REGS`, 8: general registers R0..R7, mapped to bus sources 0..7.
- `SEL_G`, 4'd8: bus source code for the ALU result register G.
- `SEL_DIN`, 4'd9: bus source code for external data-in (immediate).
- `SEL_IDLE`, 4'hF: idle select code, an undefined code that makes the mux drive 0.

Ports:
- `clk`  input  1  Single clock. All state changes on the rising edge.
- `rst`  input  1  Synchronous, active-high reset.
- `instr_valid`  input  1  Instruction present on `instr`.
- `instr_ready`  output  1  Sequencer can accept an instruction.
- `instr`  input  9  Bits [8:6] opcode, [5:3] rx, [2:0] ry.
- `ctrlVar`  output  4  Bus mux select.
- `ld_a`  output  1  Latch the bus into ALU operand register A.
- `ld_g`  output  1  Latch ALU(A, bus) into G.
- `alu_op`  output  2  ALU function: 00 add, 01 sub, 10 and, 11 unused (00 driven).
- `wr_en`  output  1  Write the bus into register `wr_addr`.
- `wr_addr`  output  3  Destination register index.
- `done`  output  1  One-cycle pulse in the final cycle of each instruction.
- `illegal`  output  1  Illegal-opcode indicator (see Configuration).

## Operation
- States: IDLE, T1, T2, T3, plus HALT (present only with the macro).
- Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 AND. Codes 101–111 are illegal.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready`, capture `instr` into an internal register and go to T1. Without valid, stay in IDLE.
- All strobes and `ctrlVar` are decoded from the state and the captured instruction (Moore). Any strobe not listed for a state is 0. `ctrlVar`=SEL_IDLE and `wr_addr`=0 in IDLE and HALT.
- MV (T1): `ctrlVar`=ry, `wr_en`=1, `wr_addr`=rx, `done`=1. Next state IDLE.
- MVI (T1): `ctrlVar`=SEL_DIN, `wr_en`=1, `wr_addr`=rx, `done`=1. Next state IDLE. The ry field is ignored. Data-in must be stable during T1; this is the caller's responsibility.
- ADD/SUB/AND:
  - T1: `ctrlVar`=rx, `ld_a`=1.
  - T2: `ctrlVar`=ry, `ld_g`=1, `alu_op` per opcode.
  - T3: `ctrlVar`=SEL_G, `wr_en`=1, `wr_addr`=rx, `done`=1. Next state IDLE.
- rx==ry is legal. ADD R2,R2 reads R2 in both T1 and T2.
- Illegal opcode: handled as described in Configuration.
- A new instruction is never accepted outside IDLE, because `instr_ready`=0. `instr` changes while busy have no effect.

## Timing
- Reset values: state IDLE, `instr_ready`=1, `ctrlVar`=4'hF, `ld_a`=`ld_g`=`wr_en`=`done`=`illegal`=0, `alu_op`=00, `wr_addr`=0, captured instruction cleared.
- Handshake in cycle N puts T1 in cycle N+1.
- Instruction lengths: MV/MVI take 1 execute cycle (`done` at N+1); ALU ops take 3 (`done` at N+3).
- Back-to-back throughput: the state returns to IDLE the cycle after `done`. The peak rate is therefore one MV every 2 cycles and one ALU op every 4 cycles.
- `rst` asserted in any state: next cycle is IDLE with reset values. The in-flight instruction is discarded and no further `wr_en` is issued for it. `rst` overrides a simultaneous handshake.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode moves T1 to HALT. T1 drives no strobes and no `done`.
  - In HALT: `illegal`=1 (sticky), `instr_ready`=0, `ctrlVar`=4'hF.
  - The only exit from HALT is `rst`.
- `SEQ_ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode executes as a NOP. T1 drives `done`=1 and no other strobes, then returns to IDLE.
  - `illegal` is tied to 0 and the HALT state does not exist.

## Test plan
- Reset, then idle 5 cycles -> `ctrlVar`=4'hF, `instr_ready`=1, all strobes 0 throughout.
- MV R3,R5 (9'b000_011_101) -> next cycle `ctrlVar`=5, `wr_en`=1, `wr_addr`=3, `done`=1; following cycle `instr_ready`=1.
- SUB R1,R6 (9'b011_001_110) -> T1 `ctrlVar`=1 with `ld_a`; T2 `ctrlVar`=6 with `ld_g` and `alu_op`=01; T3 `ctrlVar`=8 with `wr_en`, `wr_addr`=1 and `done`. `instr_ready`=0 during T1–T3.
- MVI R7 back-to-back with `instr_valid` held high -> `done` every 2nd cycle, `ctrlVar`=9 on each execute cycle. Changing `instr` while busy is ignored.
- ADD R0,R2 with `rst` asserted in T2 -> next cycle IDLE with reset values, and `wr_en` is never asserted.
- Opcode 111 -> with `SEQ_ILLEGAL_TRAP_EN`: `illegal`=1 and `instr_ready`=0 until `rst`. Without it: single `done` pulse, no `wr_en`, `illegal`=0.
